// File: rtl/mem_port_arbiter_if.sv
// Bundle between the fetch/data requesters, the memory port and the arbiter.
// The arbiter takes the slave view; the requester/memory side takes the master view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        port_ack;
  logic        addr_sel;
  logic        port_valid;
  logic [31:0] port_addr;
  logic        port_we;
  logic [31:0] port_wdata;
  logic        if_gnt;
  logic        mem_gnt;
  logic        if_done;
  logic        mem_done;
  logic        err;

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, port_ack,
    input  addr_sel, port_valid, port_addr, port_we, port_wdata,
           if_gnt, mem_gnt, if_done, mem_done, err
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, port_ack,
    output addr_sel, port_valid, port_addr, port_we, port_wdata,
           if_gnt, mem_gnt, if_done, mem_done, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin fetch/data arbiter for one memory port: grant one edge after request, done pulse one cycle after ack.
// Requesters are held off while the port is busy; `ARB_TIMEOUT_EN adds an ack watchdog that aborts with err.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_MEM} state_e;

  state_e      state_q, state_d;
  logic        last_if_q, last_if_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic        err_q, err_d;
  logic        expire;

`ifdef ARB_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;

  // Counter sits at zero in IDLE, so every SERVE entry starts from a clean count.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = 4'd0;
    end else if (!bus.port_ack) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (state_q != IDLE) && !bus.port_ack && (cnt_q == 4'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT[0];
  assign expire         = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_if_d  = last_if_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_done_d  = 1'b0;
    mem_done_d = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie, fetch wins only if the data side had the last grant.
        if (bus.if_req && (!bus.mem_req || !last_if_q)) begin
          state_d   = SERVE_IF;
          addr_d    = bus.if_addr;
          we_d      = 1'b0;
          last_if_d = 1'b1;
        end else if (bus.mem_req) begin
          state_d   = SERVE_MEM;
          addr_d    = bus.mem_addr;
          we_d      = bus.mem_we;
          wdata_d   = bus.mem_wdata;
          last_if_d = 1'b0;
        end
      end
      SERVE_IF: begin
        if (bus.port_ack) begin
          state_d   = IDLE;
          if_done_d = 1'b1;
        end else if (expire) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      SERVE_MEM: begin
        if (bus.port_ack) begin
          state_d    = IDLE;
          mem_done_d = 1'b1;
        end else if (expire) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_if_q  <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      we_q       <= 1'b0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_if_q  <= last_if_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_done_q  <= if_done_d;
      mem_done_q <= mem_done_d;
      err_q      <= err_d;
    end
  end

  assign bus.port_valid = (state_q != IDLE);
  assign bus.addr_sel   = (state_q == SERVE_IF);
  assign bus.if_gnt     = (state_q == SERVE_IF);
  assign bus.mem_gnt    = (state_q == SERVE_MEM);
  assign bus.port_addr  = addr_q;
  assign bus.port_we    = we_q;
  assign bus.port_wdata = wdata_q;
  assign bus.if_done    = if_done_q;
  assign bus.mem_done   = mem_done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; build with +define+ARB_TIMEOUT_EN for the watchdog variant.
module tb_mem_port_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TB_TO = 4;
`else
  localparam int unsigned TB_TO = 15;
`endif

  // flags = {port_valid, addr_sel, if_gnt, mem_gnt, if_done, mem_done, err}
  localparam logic [6:0] F_IDLE  = 7'b000_0000;
  localparam logic [6:0] F_SIF   = 7'b111_0000;
  localparam logic [6:0] F_SMEM  = 7'b100_1000;
  localparam logic [6:0] F_IFD   = 7'b000_0100;
  localparam logic [6:0] F_MEMD  = 7'b000_0010;
  localparam logic [6:0] F_ERR   = 7'b000_0001;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT(TB_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] flags;
  assign flags = {bus.port_valid, bus.addr_sel, bus.if_gnt, bus.mem_gnt,
                  bus.if_done, bus.mem_done, bus.err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h1234_5678;
    bus.mem_req = 1'b1; bus.mem_we = 1'b1;
    bus.mem_addr = 32'h8765_4321; bus.mem_wdata = 32'hFFFF_FFFF;
    bus.port_ack = 1'b0;
    tick(); tick();
    n_checks++; if (flags !== F_IDLE) begin n_fail++; $display("FAIL reset_flags: got %b expected %b", flags, F_IDLE); end
    n_checks++; if (bus.port_addr !== 32'h0) begin n_fail++; $display("FAIL reset_port_addr: got %h expected 0", bus.port_addr); end
    n_checks++; if (bus.port_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_port_wdata: got %h expected 0", bus.port_wdata); end
    n_checks++; if (bus.port_we !== 1'b0) begin n_fail++; $display("FAIL reset_port_we: got %b expected 0", bus.port_we); end
    bus.if_req = 1'b0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    rst = 1'b0;
    tick();
    n_checks++; if (flags !== F_IDLE) begin n_fail++; $display("FAIL post_reset_idle: got %b expected %b", flags, F_IDLE); end
  endtask

  task automatic test_round_robin();
    logic [6:0] exp_f [6];
    exp_f = '{F_SIF, F_IFD, F_SMEM, F_MEMD, F_SIF, F_IFD};
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_1000;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h0000_2000;
    bus.port_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) begin bus.if_req = 1'b0; bus.mem_req = 1'b0; bus.port_ack = 1'b0; end
      n_checks++; if (flags !== exp_f[i]) begin n_fail++; $display("FAIL rr_cycle%0d: got %b expected %b", i, flags, exp_f[i]); end
      if (i == 2) begin
        n_checks++; if (bus.port_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL rr_mem_addr: got %h expected 00002000", bus.port_addr); end
      end
    end
    tick();
    n_checks++; if (flags !== F_IDLE) begin n_fail++; $display("FAIL rr_final_idle: got %b expected %b", flags, F_IDLE); end
  endtask

  task automatic test_fetch();
    bus.if_req = 1'b1; bus.if_addr = 32'h0040_0000;
    tick();
    bus.if_req = 1'b0; bus.if_addr = 32'hCAFE_0000;
    n_checks++; if (flags !== F_SIF) begin n_fail++; $display("FAIL fetch_c1_flags: got %b expected %b", flags, F_SIF); end
    n_checks++; if (bus.port_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL fetch_addr: got %h expected 00400000", bus.port_addr); end
    n_checks++; if (bus.port_we !== 1'b0) begin n_fail++; $display("FAIL fetch_we: got %b expected 0", bus.port_we); end
    tick();
    n_checks++; if (flags !== F_SIF) begin n_fail++; $display("FAIL fetch_c2_flags: got %b expected %b", flags, F_SIF); end
    n_checks++; if (bus.port_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL fetch_addr_hold: got %h expected 00400000", bus.port_addr); end
    bus.port_ack = 1'b1;
    tick();
    bus.port_ack = 1'b0;
    n_checks++; if (flags !== F_IFD) begin n_fail++; $display("FAIL fetch_done: got %b expected %b", flags, F_IFD); end
    tick();
    n_checks++; if (flags !== F_IDLE) begin n_fail++; $display("FAIL fetch_done_once: got %b expected %b", flags, F_IDLE); end
  endtask

  task automatic test_store();
    bus.mem_req = 1'b1; bus.mem_we = 1'b1;
    bus.mem_addr = 32'h1001_0000; bus.mem_wdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    bus.mem_addr = 32'hFFFF_FFFF; bus.mem_wdata = 32'h0; bus.if_addr = 32'h5555_5555;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) bus.if_req = 1'b1;
      n_checks++; if (flags !== F_SMEM) begin n_fail++; $display("FAIL store_c%0d_flags: got %b expected %b", c, flags, F_SMEM); end
      n_checks++; if ({bus.port_we, bus.port_addr, bus.port_wdata} !== {1'b1, 32'h1001_0000, 32'hDEAD_BEEF})
        begin n_fail++; $display("FAIL store_c%0d_latch: got we=%b addr=%h wdata=%h expected we=1 addr=10010000 wdata=deadbeef", c, bus.port_we, bus.port_addr, bus.port_wdata); end
      if (c == 3) bus.port_ack = 1'b1;
      tick();
    end
    bus.port_ack = 1'b0; bus.if_req = 1'b0;
    n_checks++; if (flags !== F_MEMD) begin n_fail++; $display("FAIL store_done: got %b expected %b", flags, F_MEMD); end
    tick();
    n_checks++; if (flags !== F_IDLE) begin n_fail++; $display("FAIL store_done_once: got %b expected %b", flags, F_IDLE); end
  endtask

  task automatic test_reset_mid();
    bus.mem_req = 1'b1; bus.mem_we = 1'b1;
    bus.mem_addr = 32'h2000_0040; bus.mem_wdata = 32'h0BAD_F00D;
    tick();
    n_checks++; if (flags !== F_SMEM) begin n_fail++; $display("FAIL rstmid_c1: got %b expected %b", flags, F_SMEM); end
    bus.mem_req = 1'b0;
    tick();
    rst = 1'b1;
    bus.port_ack = 1'b1;
    tick();
    rst = 1'b0; bus.port_ack = 1'b0;
    n_checks++; if (flags !== F_IDLE) begin n_fail++; $display("FAIL rstmid_flags: got %b expected %b", flags, F_IDLE); end
    n_checks++; if ({bus.port_we, bus.port_addr, bus.port_wdata} !== 65'h0)
      begin n_fail++; $display("FAIL rstmid_port: got we=%b addr=%h wdata=%h expected all 0", bus.port_we, bus.port_addr, bus.port_wdata); end
    tick();
    n_checks++; if (flags !== F_IDLE) begin n_fail++; $display("FAIL rstmid_no_done: got %b expected %b", flags, F_IDLE); end
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0400; bus.mem_req = 1'b1;
    tick();
    bus.if_req = 1'b0; bus.mem_req = 1'b0; bus.port_ack = 1'b1;
    n_checks++; if (flags !== F_SIF) begin n_fail++; $display("FAIL rstmid_tie_if: got %b expected %b", flags, F_SIF); end
    tick();
    bus.port_ack = 1'b0;
    n_checks++; if (flags !== F_IFD) begin n_fail++; $display("FAIL rstmid_tie_done: got %b expected %b", flags, F_IFD); end
    tick();
  endtask

  task automatic test_timeout();
`ifdef ARB_TIMEOUT_EN
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h0000_3000;
    tick();
    bus.mem_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_checks++; if (flags !== F_SMEM) begin n_fail++; $display("FAIL to_wait_c%0d: got %b expected %b", c, flags, F_SMEM); end
      tick();
    end
    n_checks++; if (flags !== F_ERR) begin n_fail++; $display("FAIL to_err: got %b expected %b", flags, F_ERR); end
    tick();
    n_checks++; if (flags !== F_IDLE) begin n_fail++; $display("FAIL to_err_once: got %b expected %b", flags, F_IDLE); end
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_4000;
    tick();
    bus.if_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_checks++; if (flags !== F_SIF) begin n_fail++; $display("FAIL to_ack_c%0d: got %b expected %b", c, flags, F_SIF); end
      if (c == 4) bus.port_ack = 1'b1;
      tick();
    end
    bus.port_ack = 1'b0;
    n_checks++; if (flags !== F_IFD) begin n_fail++; $display("FAIL to_ack_done: got %b expected %b", flags, F_IFD); end
    tick();
`else
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_4000;
    tick();
    bus.if_req = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      n_checks++; if (flags !== F_SIF) begin n_fail++; $display("FAIL nowd_c%0d: got %b expected %b", c, flags, F_SIF); end
      tick();
    end
    bus.port_ack = 1'b1;
    tick();
    bus.port_ack = 1'b0;
    n_checks++; if (flags !== F_IFD) begin n_fail++; $display("FAIL nowd_done: got %b expected %b", flags, F_IFD); end
    tick();
`endif
    n_checks++; if (flags !== F_IDLE) begin n_fail++; $display("FAIL to_final_idle: got %b expected %b", flags, F_IDLE); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
    bus.port_ack = 1'b0;
    test_reset();
    test_round_robin();
    test_fetch();
    test_store();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
